// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, word-length codes and frame helpers.
// Used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef logic [1:0] wls_t;

    localparam wls_t WLS_5 = 2'b00;
    localparam wls_t WLS_6 = 2'b01;
    localparam wls_t WLS_7 = 2'b10;
    localparam wls_t WLS_8 = 2'b11;

    // Number of data bits in a frame for a given LCR word-length code.
    function automatic logic [3:0] data_bits(wls_t wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    // Mask selecting the valid data bits of a byte for a given word length.
    function automatic logic [7:0] data_mask(wls_t wls);
        return 8'hFF >> (2'd3 - wls);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and serialises 16550-style frames
// onto a registered txd, timed by the oversampled baud tick.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OSR = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       baud_tick,
    input  logic [1:0] lcr_wls,
    input  logic       lcr_stb,
    input  logic       lcr_pen,
    input  logic       lcr_eps,
    input  logic       lcr_sp,
    input  logic       lcr_brk,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       txd,
    output logic       busy,
    output logic       temt
);

    localparam int unsigned TW = $clog2(2 * OSR);

    typedef logic [TW-1:0] tick_t;

    localparam tick_t BIT_LAST    = tick_t'(OSR - 1);
    localparam tick_t STOP15_LAST = tick_t'((OSR * 3) / 2 - 1);
    localparam tick_t STOP2_LAST  = tick_t'(2 * OSR - 1);

    tx_state_e  state_q, state_d;
    tick_t      tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    wls_t       wls_q;
    logic       stb_q;
    logic       pen_q;
    logic       eps_q;
    logic       sp_q;
    logic       par_q;
    logic       txd_q;

    tick_t      bit_last;
    logic       bit_end;
    logic       data_last;
    logic       pop_req;
    logic       txd_val;

    // Length of the current bit period; only STOP can differ from one bit time.
    always_comb begin
        bit_last = BIT_LAST;
        if (state_q == TX_STOP && stb_q) begin
            bit_last = (wls_q == WLS_5) ? STOP15_LAST : STOP2_LAST;
        end
    end

    assign bit_end   = baud_tick && (tick_cnt_q == bit_last);
    assign data_last = ({1'b0, bit_cnt_q} == (data_bits(wls_q) - 4'd1));

    // Next-state, pop decision and serial bit value.
    always_comb begin
        state_d = state_q;
        pop_req = 1'b0;
        txd_val = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                txd_val = 1'b0;
                if (bit_end) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_val = shreg_q[0];
                if (bit_end && data_last) begin
                    state_d = pen_q ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                txd_val = sp_q ? ~eps_q : (eps_q ? par_q : ~par_q);
                if (bit_end) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop_req = 1'b1;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_cnt_q <= '0;
        end else if (state_q == TX_IDLE || pop_req) begin
            tick_cnt_q <= '0;
        end else if (baud_tick) begin
            tick_cnt_q <= bit_end ? '0 : tick_cnt_q + tick_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt_q <= '0;
        end else if (state_q != TX_DATA) begin
            bit_cnt_q <= '0;
        end else if (bit_end) begin
            bit_cnt_q <= data_last ? 3'd0 : bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg_q <= '0;
        end else if (pop_req) begin
            shreg_q <= fifo_data;
        end else if (state_q == TX_DATA && bit_end) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
        end
    end

    // Frame configuration and parity are captured with the byte so LCR writes
    // mid-frame only take effect on the next frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wls_q <= WLS_5;
            stb_q <= 1'b0;
            pen_q <= 1'b0;
            eps_q <= 1'b0;
            sp_q  <= 1'b0;
            par_q <= 1'b0;
        end else if (pop_req) begin
            wls_q <= lcr_wls;
            stb_q <= lcr_stb;
            pen_q <= lcr_pen;
            eps_q <= lcr_eps;
            sp_q  <= lcr_sp;
            par_q <= ^(fifo_data & data_mask(lcr_wls));
        end
    end

    // Break is applied live, ahead of the output register, without disturbing the FSM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            txd_q <= 1'b1;
        end else begin
            txd_q <= lcr_brk ? 1'b0 : txd_val;
        end
    end

    assign fifo_pop = pop_req && rstn;
    assign txd      = txd_q;
    assign busy     = (state_q != TX_IDLE);
    assign temt     = (state_q == TX_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: checks frame bit values mid-bit and frame lengths in
// baud ticks against hand-computed expectations, with a simple FIFO model.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       baud_tick = 1'b0;
    logic [1:0] lcr_wls = 2'b11;
    logic       lcr_stb = 1'b0;
    logic       lcr_pen = 1'b0;
    logic       lcr_eps = 1'b0;
    logic       lcr_sp = 1'b0;
    logic       lcr_brk = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_pop;
    logic       txd;
    logic       busy;
    logic       temt;

    logic [7:0] q[$];
    int         pops = 0;
    int         tick_no = 0;
    int         bcnt = 0;
    int         errors = 0;
    int         checks = 0;
    int         viol = 0;
    int         busy_gaps = 0;
    logic       watch = 1'b0;
    logic       prev_pop = 1'b0;
    logic       pop_seen;

    uart_tx_ctrl #(.OSR(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .baud_tick  (baud_tick),
        .lcr_wls    (lcr_wls),
        .lcr_stb    (lcr_stb),
        .lcr_pen    (lcr_pen),
        .lcr_eps    (lcr_eps),
        .lcr_sp     (lcr_sp),
        .lcr_brk    (lcr_brk),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .busy       (busy),
        .temt       (temt)
    );

    always #5 clk = ~clk;

    // One baud tick every four clocks, driven away from the sampling edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            baud_tick = (bcnt == 3);
            bcnt = (bcnt + 1) % 4;
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_no <= tick_no + 1;
    end

    // FIFO model: pops the head on every edge where the DUT asserted fifo_pop.
    initial begin
        forever begin
            @(negedge clk);
            pop_seen = fifo_pop;
            @(posedge clk);
            #1;
            if (pop_seen && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            fifo_empty = (q.size() == 0);
            fifo_data  = fifo_empty ? 8'h00 : q[0];
        end
    end

    always @(negedge clk) begin
        if (fifo_pop && (fifo_empty || prev_pop)) viol <= viol + 1;
        prev_pop <= fifo_pop;
        if (watch && !busy) busy_gaps <= busy_gaps + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_lcr(input logic [1:0] wls, input logic stb, input logic pen,
                           input logic eps, input logic sp);
        lcr_wls = wls;
        lcr_stb = stb;
        lcr_pen = pen;
        lcr_eps = eps;
        lcr_sp  = sp;
    endtask

    task automatic wait_ticks(input int n);
        while (tick_no < n) @(negedge clk);
    endtask

    // Returns the tick count just after the pop edge, where the START bit begins.
    task automatic wait_pop(input string tag, output int t0);
        int n = 0;
        while (!fifo_pop && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!fifo_pop) check({tag, "_pop_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        t0 = tick_no;
        @(negedge clk);
    endtask

    // Frame ends either when busy drops or on the pop of the next byte.
    task automatic wait_end(input string tag, input int t0, input int total);
        int n = 0;
        while (busy && !fifo_pop && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check({tag, "_end_timeout"}, 32'd0, 32'd1);
        check({tag, "_ticks"}, fifo_pop ? tick_no + 1 - t0 : tick_no - t0, total);
    endtask

    task automatic check_frame(input string tag, input string bits, input int total);
        int t0;
        wait_pop(tag, t0);
        for (int i = 0; i < bits.len(); i++) begin
            wait_ticks(t0 + 16 * i + 8);
            check($sformatf("%s_bit%0d", tag, i), txd, (bits[i] == "1") ? 1 : 0);
        end
        wait_end(tag, t0, total);
    endtask

    initial begin
        int t0;
        int p0;

        repeat (5) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_pop", fifo_pop, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("idle_temt", temt, 1);
        check("idle_txd", txd, 1);

        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        q.push_back(8'hA5);
        check_frame("8n1_a5", "0101001011", 160);
        @(negedge clk);
        check("8n1_temt", temt, 1);
        check("8n1_pops", pops, 1);

        set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        q.push_back(8'h35);
        check_frame("7e1", "0101011001", 160);
        set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        q.push_back(8'h35);
        check_frame("7s1_eps1", "0101011001", 160);
        set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
        q.push_back(8'h35);
        check_frame("7s1_eps0", "0101011011", 160);
        set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        q.push_back(8'h35);
        check_frame("7o1", "0101011011", 160);

        // LCR rewritten during the 5-bit frame applies only to the queued 6-bit frame.
        set_lcr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        q.push_back(8'h0D);
        q.push_back(8'h2A);
        fork
            check_frame("5n15", "0101101", 120);
            begin
                repeat (60) @(negedge clk);
                set_lcr(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        join
        check_frame("6n2", "00101011", 144);

        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        p0 = pops;
        q.push_back(8'h01);
        q.push_back(8'h80);
        q.push_back(8'hC3);
        check_frame("b2b_0", "0100000001", 160);
        watch = 1'b1;
        check_frame("b2b_1", "0000000011", 160);
        watch = 1'b0;
        check_frame("b2b_2", "0110000111", 160);
        check("b2b_pops", pops - p0, 3);
        check("b2b_busy_gaps", busy_gaps, 0);

        q.push_back(8'hFF);
        wait_pop("rst_mid", t0);
        wait_ticks(t0 + 16 * 3 + 5);
        p0 = pops;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        q.push_back(8'h3C);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_txd", txd, 1);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("rst_mid_nopop", fifo_pop, 0);
        check("rst_mid_pops", pops, p0);
        check("rst_mid_qsize", q.size(), 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_frame("rst_next", "0001111001", 160);

        q.push_back(8'hFF);
        q.push_back(8'h5A);
        wait_pop("brk", t0);
        wait_ticks(t0 + 20);
        lcr_brk = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_ticks(t0 + 22 + 4 * k);
            check($sformatf("brk_low%0d", k), txd, 0);
        end
        wait_ticks(t0 + 60);
        lcr_brk = 1'b0;
        wait_ticks(t0 + 16 * 5 + 8);
        check("brk_release", txd, 1);
        wait_end("brk", t0, 160);
        check_frame("after_brk", "0010110101", 160);

        check("pop_rules", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
